// File: rtl/ttt_event_pkg.sv
// ttt_event_pkg: shared sizes, startstop encoding and the buffered event record layout.
package ttt_event_pkg;
    localparam int NUM_PROCESSORS = 10;
    localparam int TIMESTAMP_BITS = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int PID_BITS = $clog2(NUM_PROCESSORS);
    localparam int REC_BITS = 1 + TIMESTAMP_BITS + PID_BITS + 2;
    localparam int FILL_BITS = $clog2(FIFO_DEPTH) + 1;
    localparam int DROP_COUNT_BITS = 8;
    typedef enum logic [1:0] {SS_NONE, SS_START, SS_STOP, SS_BOTH} startstop_e;
    typedef struct packed {
        logic                      wrapped;
        logic [TIMESTAMP_BITS-1:0] timestamp;
        logic [PID_BITS-1:0]       processor_id;
        startstop_e                startstop;
    } event_rec_t;
endpackage

// File: rtl/ttt_event_collector_if.sv
// ttt_event_collector_if: core event input plus host valid/ready readout.
interface ttt_event_collector_if;
    import ttt_event_pkg::*;
    logic                evt_valid;
    logic [PID_BITS-1:0] evt_processor_id;
    startstop_e          evt_startstop;
    logic                rd_valid;
    logic                rd_ready;
    event_rec_t          rd_data;
    modport master (output evt_valid, evt_processor_id, evt_startstop, rd_ready, input rd_valid, rd_data);
    modport slave (input evt_valid, evt_processor_id, evt_startstop, rd_ready, output rd_valid, rd_data);
endinterface

// File: rtl/ttt_sync_fifo.sv
// ttt_sync_fifo: show-ahead synchronous FIFO; a push into a full FIFO is taken only alongside a pop.
module ttt_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic do_push, do_pop;
    always_comb begin
        empty = wr_q == rd_q;
        full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        count = wr_q - rd_q;
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d = clear ? '0 : wr_q + (AW+1)'(do_push);
        rd_d = clear ? '0 : rd_q + (AW+1)'(do_pop);
        dout = empty ? '0 : mem_q[rd_q[AW-1:0]];
    end
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    always_ff @(posedge clock)
        if (do_push && !clear) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/ttt_event_collector.sv
// ttt_event_collector: timestamps qualified core events and buffers them for host readout.
module ttt_event_collector
    import ttt_event_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       tick,
    ttt_event_collector_if.slave       evt,
    output logic [FILL_BITS-1:0]       fill_level,
    output logic                       overflow,
    output logic [DROP_COUNT_BITS-1:0] drop_count
);
    localparam logic [PID_BITS:0] NP = (PID_BITS+1)'(NUM_PROCESSORS);
    logic [TIMESTAMP_BITS-1:0] ts_q, ts_d;
    logic [DROP_COUNT_BITS-1:0] drop_q, drop_d;
    logic wrap_q, wrap_d, ovf_q, ovf_d;
    logic hit, bad, qual, pop, accept, lost, full, empty;
    event_rec_t rec;
    logic [REC_BITS-1:0] dout;
    always_comb begin
        hit = evt.evt_valid && evt.evt_startstop != SS_NONE;
        bad = hit && {1'b0, evt.evt_processor_id} >= NP;
        qual = hit && !bad;
        pop = !empty && evt.rd_ready;
        accept = qual && (!full || pop);
        lost = qual && !accept;
        rec = '{wrapped: wrap_q, timestamp: ts_q, processor_id: evt.evt_processor_id, startstop: evt.evt_startstop};
        ts_d = clear ? '0 : ts_q + TIMESTAMP_BITS'(tick);
        // a wrap in the same cycle as a push must survive for the next record
        wrap_d = clear ? 1'b0 : (tick && &ts_q) ? 1'b1 : accept ? 1'b0 : wrap_q;
        ovf_d = !clear && (ovf_q || lost);
        drop_d = clear ? '0 : ((bad || lost) && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
    end
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            ts_q <= '0;
            wrap_q <= 1'b0;
            ovf_q <= 1'b0;
            drop_q <= '0;
        end else begin
            ts_q <= ts_d;
            wrap_q <= wrap_d;
            ovf_q <= ovf_d;
            drop_q <= drop_d;
        end
    ttt_sync_fifo #(.WIDTH(REC_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock(clock),
        .reset_n(reset_n),
        .clear(clear),
        .push(qual),
        .pop(pop),
        .din(rec),
        .dout(dout),
        .full(full),
        .empty(empty),
        .count(fill_level)
    );
    assign evt.rd_data = event_rec_t'(dout);
    assign evt.rd_valid = !empty;
    assign overflow = ovf_q;
    assign drop_count = drop_q;
endmodule
